axil_cmd_master: RTL



---
 rtl/axil_cmd_master_if.sv | 55 +++++
 rtl/axil_cmd_master.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/axil_cmd_master_if.sv
// -----------------------------------------------------------------------------
// axil_cmd_master_if
// AXI4-Lite bus bundle: the AW, W, B, AR and R channels.
//   master modport : drives aw*/w*/ar* payload and valid, bready, rready
//   slave modport  : drives awready, wready, b*, arready, r*
// Parameters:
//   DATA_WIDTH : data bus width in bits (multiple of 8)
//   ADDR_WIDTH : byte address width in bits
//   STRB_WIDTH : write strobe width (DATA_WIDTH/8)
// -----------------------------------------------------------------------------
interface axil_cmd_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;

    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid,    input wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid,    output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input rready
    );
endinterface

// File: rtl/axil_cmd_master.sv
// -----------------------------------------------------------------------------
// axil_cmd_master
// Turns single-word commands from a valid/ready command port into AXI4-Lite
// read or write transactions and returns one response per command on a
// valid/ready response port. One transaction is in flight at a time.
// Ports:
//   clk, rst                 : clock (rising edge), async active-high reset
//   cmd_addr/data/strb/write : command payload, sampled on cmd handshake
//   cmd_valid / cmd_ready    : command handshake (ready only when idle)
//   rsp_data/resp/write      : response payload, stable while rsp_valid
//   rsp_valid / rsp_ready    : response handshake
//   m_axil                   : AXI4-Lite master bus (interface, master modport)
// -----------------------------------------------------------------------------
module axil_cmd_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic [STRB_WIDTH-1:0] cmd_strb,
    input  logic                  cmd_write,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,

    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_write,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,

    axil_cmd_master_if.master     m_axil
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESP
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [STRB_WIDTH-1:0] r_strb;
    logic                  r_write;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic                  r_arvalid;
    logic                  r_rready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic [1:0]            r_rsp_resp;

    // A write channel is "done" once its valid has dropped or its handshake
    // lands this cycle; the two channels complete in any order.
    logic w_aw_done;
    logic w_w_done;

    assign w_aw_done = !r_awvalid || m_axil.awready;
    assign w_w_done  = !r_wvalid  || m_axil.wready;

    assign cmd_ready = (r_state == IDLE);

    // Bus payload comes straight from the registered command, so it cannot
    // change while the corresponding valid is high.
    assign m_axil.awaddr  = r_addr;
    assign m_axil.awprot  = 3'b000;
    assign m_axil.awvalid = r_awvalid;
    assign m_axil.wdata   = r_data;
    assign m_axil.wstrb   = r_strb;
    assign m_axil.wvalid  = r_wvalid;
    assign m_axil.bready  = r_bready;
    assign m_axil.araddr  = r_addr;
    assign m_axil.arprot  = 3'b000;
    assign m_axil.arvalid = r_arvalid;
    assign m_axil.rready  = r_rready;

    assign rsp_data  = r_rsp_data;
    assign rsp_resp  = r_rsp_resp;
    assign rsp_write = r_write;
    assign rsp_valid = r_rsp_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: every register, payload included, is reset so that all
            // outputs hold defined values the moment rst rises.
            r_state     <= IDLE;
            r_addr      <= '0;
            r_data      <= '0;
            r_strb      <= '0;
            r_write     <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_resp  <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // reads the pre-edge register values regardless of statement order.
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_addr  <= cmd_addr;
                        r_data  <= cmd_data;
                        r_strb  <= cmd_strb;
                        r_write <= cmd_write;
                        if (cmd_write) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= WR;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= RD_ADDR;
                        end
                    end
                end

                WR: begin
                    if (r_awvalid && m_axil.awready) r_awvalid <= 1'b0;
                    if (r_wvalid && m_axil.wready)   r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (m_axil.bvalid) begin
                        r_bready    <= 1'b0;
                        r_rsp_resp  <= m_axil.bresp;
                        r_rsp_data  <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
                end

                RD_ADDR: begin
                    if (m_axil.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (m_axil.rvalid) begin
                        r_rready    <= 1'b0;
                        r_rsp_data  <= m_axil.rdata;
                        r_rsp_resp  <= m_axil.rresp;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
